// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid stage: state encoding and default counter width.
package pipe_pkg;

   localparam int PIPE_CNT_W = 16;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b11
   } pipe_state_t;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module pipe_sat_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline register with 2-entry skid; latency 1, full throughput, registered ready.
// Optional stall/bubble counters under PIPE_SKID_PERF_EN (ports tied to 0 otherwise).
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int CLEAR_ON_EMPTY = 1,
   parameter int CNT_W          = PIPE_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt
);

   pipe_state_t      state_q, state_nxt;
   logic [WIDTH-1:0] main_q, main_nxt;
   logic [WIDTH-1:0] skid_q, skid_nxt;
   logic             in_fire, out_fire;

   // Both handshake outputs decode from state only, so out_ready never reaches in_ready.
   assign in_ready  = (state_q != ST_FULL) && !rst;
   assign out_valid = (state_q != ST_EMPTY);
   assign out_data  = main_q;
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;

   always_comb begin
      state_nxt = state_q;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
      if (flush) begin
         state_nxt = ST_EMPTY;
         if ((state_q != ST_EMPTY) && (CLEAR_ON_EMPTY != 0)) begin
            main_nxt = '0;
         end
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_nxt = ST_ONE;
                  main_nxt  = in_data;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  main_nxt = in_data;
               end else if (in_fire) begin
                  state_nxt = ST_FULL;
                  skid_nxt  = in_data;
               end else if (out_fire) begin
                  state_nxt = ST_EMPTY;
                  if (CLEAR_ON_EMPTY != 0) begin
                     main_nxt = '0;
                  end
               end
            end
            ST_FULL: begin
               if (out_fire) begin
                  state_nxt = ST_ONE;
                  main_nxt  = skid_q;
               end
            end
            default: state_nxt = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_nxt;
         main_q  <= main_nxt;
         skid_q  <= skid_nxt;
      end
   end

`ifdef PIPE_SKID_PERF_EN
   pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .clr (rst),
      .inc (out_valid && !out_ready),
      .cnt (stall_cnt)
   );

   pipe_sat_cnt #(.W(CNT_W)) u_bubble_cnt (
      .clk (clk),
      .clr (rst),
      .inc (!out_valid),
      .cnt (bubble_cnt)
   );
`else
   assign stall_cnt  = '0;
   assign bubble_cnt = '0;
`endif

endmodule
